// File: rtl/mag_sched.sv
// mag_sched: round-robin arbiter feeding a shared 17-bit signed magnitude unit with ready/valid output
module mag_sched #(
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [17*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [15:0]            out_data,
   output logic [2:0]             out_id,
   output logic                   out_sat,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
   state_t state, state_nx;
   logic [2:0] ptr, id, win, off;
   logic [16:0] operand, sel;
   logic [2*NUM_REQ-1:0] dbl;
   logic [15:0] mag;
   logic sat;
   assign dbl = {req, req} >> ptr;
   always_comb begin
      off = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) if (dbl[j]) off = 3'(j);
      win = 3'((int'(ptr) + int'(off)) % NUM_REQ);
      sel = '0;
      for (int j = 0; j < NUM_REQ; j++) if (3'(j) == win) sel = req_data[17*j +: 17];
   end
   assign sat = operand == 17'h10000;
   assign mag = sat ? 16'hFFFF : operand[16] ? ~operand[15:0] + 16'd1 : operand[15:0];
   assign busy = state != IDLE;
   always_comb begin
      state_nx = state == IDLE ? (|req ? CALC : IDLE) :
                 state == CALC ? HOLD :
                 (out_ready ? IDLE : HOLD);
   end
   always_ff @(posedge clk) begin
      if (!n_rst) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         ptr       <= '0;
         id        <= '0;
         operand   <= '0;
         ack       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         out_sat   <= 1'b0;
      end else begin
         ack <= '0;
         if (state == IDLE && |req) begin
            operand <= sel;
            id      <= win;
            ack     <= NUM_REQ'(1) << win;
         end
         if (state == CALC) begin
            out_data  <= mag;
            out_id    <= id;
            out_sat   <= sat;
            out_valid <= 1'b1;
         end
         if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            ptr       <= id == 3'(NUM_REQ - 1) ? 3'd0 : id + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_mag_sched.sv
// tb_mag_sched: transaction-level reference model plus directed and randomized checks for mag_sched
module tb_mag_sched;
   localparam int N = 4;
   logic clk = 1'b0, n_rst = 1'b0, out_ready = 1'b0;
   logic [N-1:0] req = '0;
   logic [17*N-1:0] req_data = '0;
   logic [N-1:0] ack;
   logic out_valid, out_sat, busy;
   logic [15:0] out_data;
   logic [2:0] out_id;
   int vectors = 0, miscompares = 0;
   bit check_en = 1'b0;
   int m_phase, m_ptr, m_id, m_oid;
   logic [16:0] m_op, m_r;
   logic [N-1:0] m_ack;
   logic m_valid, m_sat;
   logic [15:0] m_data;

   mag_sched #(.NUM_REQ(N)) dut (
      .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .ack(ack),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .out_sat(out_sat), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] magf(input logic [16:0] x);
      int v;
      v = x[16] ? int'(x) - 131072 : int'(x);
      if (v < 0) v = -v;
      return v > 65535 ? {1'b1, 16'hFFFF} : {1'b0, v[15:0]};
   endfunction

   function automatic int arb(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   function automatic void chk(input string n, input int a, input int e);
      vectors++;
      if (a != e) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", n, a, e, $time);
      end
   endfunction

   // Model: phase counts progress through one transaction (0 waiting, 1 computing, 2 presenting)
   always @(posedge clk) begin
      if (!n_rst) begin
         m_phase = 0; m_ptr = 0; m_id = 0; m_op = '0; m_ack = '0;
         m_valid = 0; m_data = '0; m_oid = 0; m_sat = 0; check_en = 1'b1;
      end else begin
         m_ack = '0;
         if (m_phase == 0) begin
            if (req != 0) begin
               m_id = arb(req, m_ptr);
               m_op = req_data[17*m_id +: 17];
               m_ack[m_id] = 1'b1;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_r = magf(m_op);
            m_data = m_r[15:0]; m_sat = m_r[16]; m_oid = m_id; m_valid = 1; m_phase = 2;
         end else if (out_ready) begin
            m_valid = 0; m_ptr = (m_id + 1) % N; m_phase = 0;
         end
      end
   end

   always @(negedge clk) if (check_en) begin
      chk("ack", ack, m_ack);
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_id", out_id, m_oid);
      chk("out_sat", out_sat, m_sat);
      chk("busy", busy, m_phase != 0);
   end

   task automatic do_reset();
      @(negedge clk); n_rst = 1'b0; req = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic one(input logic [N-1:0] r, input logic [16:0] s, input int eid,
                      input logic [15:0] ed, input logic es, input string tag);
      bit got = 0;
      @(negedge clk);
      req = r; out_ready = 1'b1;
      for (int i = 0; i < N; i++) req_data[17*i +: 17] = s;
      for (int c = 0; c < 12 && !got; c++) begin
         @(negedge clk);
         if (ack != 0) begin chk({tag, " ack"}, ack, 1 << eid); req = '0; end
         if (out_valid) begin
            chk({tag, " data"}, out_data, ed);
            chk({tag, " id"}, out_id, eid);
            chk({tag, " sat"}, out_sat, es);
            got = 1;
         end
      end
      if (!got) chk({tag, " timeout"}, 0, 1);
      @(negedge clk); chk({tag, " busy"}, busy, 0);
   endtask

   function automatic logic [16:0] rnd_sample();
      int k = $urandom_range(0, 5);
      return k == 0 ? 17'h10000 : k == 1 ? 17'h18000 : k == 2 ? 17'h1FFFF : 17'($urandom);
   endfunction

   initial begin
      int cnt;
      bit got;
      repeat (3) @(negedge clk);
      chk("rst out_valid", out_valid, 0);
      chk("rst ack", ack, 0);
      chk("rst busy", busy, 0);
      n_rst = 1'b1;
      one(4'b0001, 17'h00005, 0, 16'h0005, 1'b0, "pos5");
      one(4'b0001, 17'h1FFFB, 0, 16'h0005, 1'b0, "neg5");
      one(4'b0010, 17'h10000, 1, 16'hFFFF, 1'b1, "sat");
      one(4'b0100, 17'h18000, 2, 16'h8000, 1'b0, "m8000");
      // round robin with every requester asserted
      do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) req_data[17*i +: 17] = 17'(i + 1);
      req = 4'b1111; out_ready = 1'b1; cnt = 0;
      for (int c = 0; c < 40 && cnt < 5; c++) begin
         @(negedge clk);
         if (ack != 0) chk("rr onehot", $countones(ack), 1);
         if (out_valid) begin chk("rr id", out_id, cnt % N); cnt++; end
      end
      if (cnt < 5) chk("rr timeout", cnt, 5);
      req = '0;
      // backpressure in HOLD with a competing request
      do_reset();
      @(negedge clk);
      req_data[16:0] = 17'h00123; req = 4'b0001;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (ack[0]) begin req = '0; got = 1; end
      end
      if (!got) chk("bp ack timeout", 0, 1);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); got = out_valid; end
      if (!got) chk("bp valid timeout", 0, 1);
      req_data[33:17] = 17'h1FFFF; req = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp valid", out_valid, 1);
         chk("bp data", out_data, 16'h0123);
         chk("bp ack", ack, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp release valid", out_valid, 0);
      chk("bp release ack", ack, 0);
      @(negedge clk);
      chk("bp late ack", ack, 4'b0010);
      req = '0;
      @(negedge clk);
      chk("bp late data", out_data, 16'h0001);
      chk("bp late id", out_id, 1);
      // reset during CALC
      do_reset();
      out_ready = 1'b1;
      @(negedge clk); req_data[16:0] = 17'h00077; req = 4'b0001;
      @(negedge clk); chk("rc ack", ack, 4'b0001);
      n_rst = 1'b0; req = '0;
      @(negedge clk);
      chk("rc valid", out_valid, 0);
      chk("rc ack0", ack, 0);
      chk("rc busy", busy, 0);
      chk("rc data", out_data, 0);
      chk("rc id", out_id, 0);
      n_rst = 1'b1;
      repeat (3) begin @(negedge clk); chk("rc no pulse", out_valid, 0); end
      one(4'b0100, 17'h00042, 2, 16'h0042, 1'b0, "rc serve");
      // randomized traffic
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         n_rst = $urandom_range(0, 199) != 0;
         for (int i = 0; i < N; i++) begin
            if (ack[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               req_data[17*i +: 17] = rnd_sample();
            end
         end
         out_ready = $urandom_range(0, 9) < 6;
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
